// File: rtl/sdmf_triple_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdmf_triple_pkg
//  Description : Shared field layout, key helper and FSM encoding for the
//                triple accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdmf_triple_pkg;

   // Triple layout {ch, t, v}
   localparam int DW     = 24;
   localparam int SW     = 8;
   localparam int TW     = 8;
   localparam int CW     = 8;
   localparam int VW     = DW - SW - TW;
   localparam int KW     = SW + TW;
   localparam int CH_MSB = DW - 1;
   localparam int T_MSB  = DW - SW - 1;
   localparam int V_MSB  = VW - 1;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ACC   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Merge key {ch, t}: everything above the value field
   function automatic logic [KW-1:0] key_of(input logic [DW-1:0] d);
      return KW'(d >> VW);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdmf_triple_accum_sat_add.sv
`default_nettype none
// ============================================================================
//  Module      : sdmf_triple_accum_sat_add
//  Description : Unsigned W-bit adder that clamps at all-ones and flags the
//                clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdmf_triple_accum_sat_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_sum,
   output logic         o_ovf
);

   logic [W:0] w_full;

   // One extra bit catches the carry; clamp to max when it is set
   always_comb begin
      w_full = {1'b0, i_a} + {1'b0, i_b};
      o_ovf  = w_full[W];
      o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
   end

endmodule
`default_nettype wire

// File: rtl/sdmf_triple_accum.sv
`default_nettype none
// ============================================================================
//  Module      : sdmf_triple_accum
//  Description : Collapses adjacent triples with equal {ch, t} into one,
//                summing values with saturation; frames end on last.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdmf_triple_accum
   import sdmf_triple_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_valid,
   output logic          i_ready,
   input  logic          i_last,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   input  logic          o_ready,
   output logic          o_last,
   output logic [DW-1:0] o_data,
   output logic [CW-1:0] o_hits,
   output logic          o_sat
);

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_live;
   logic [KW-1:0] r_acc_key;
   logic [VW-1:0] r_acc_sum;
   logic [CW-1:0] r_acc_hits;
   logic          r_acc_sat;
   logic          r_o_valid;
   logic          r_o_last;
   logic [DW-1:0] r_o_data;
   logic [CW-1:0] r_o_hits;
   logic          r_o_sat;

   logic          w_out_free;
   logic          w_accept;
   logic          w_key_eq;
   logic          w_load;
   logic          w_merge;
   logic          w_emit;
   logic          w_emit_last;
   logic [VW-1:0] w_sum_add;
   logic          w_sum_ovf;
   logic [CW-1:0] w_hits_add;
   logic          w_hits_ovf;

   // i_ready depends only on registered state and o_ready, never on i_valid
   assign w_out_free = !r_o_valid || o_ready;
   assign i_ready    = r_live && (r_state != ST_DRAIN) && w_out_free;
   assign w_accept   = i_valid && i_ready;
   assign w_key_eq   = (key_of(i_data) == r_acc_key);

   sdmf_triple_accum_sat_add #(.W(VW)) u_sum_add (
      .i_a   (r_acc_sum),
      .i_b   (i_data[V_MSB:0]),
      .o_sum (w_sum_add),
      .o_ovf (w_sum_ovf)
   );

   sdmf_triple_accum_sat_add #(.W(CW)) u_hits_add (
      .i_a   (r_acc_hits),
      .i_b   ({{(CW-1){1'b0}}, 1'b1}),
      .o_sum (w_hits_add),
      .o_ovf (w_hits_ovf)
   );

   // State register plus a flag that holds i_ready low until the first edge out of reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_EMPTY;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_live  <= 1'b1;
      end
   end

   // Next state and per-cycle actions: load, merge, emit (with or without last)
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_merge     = 1'b0;
      w_emit      = 1'b0;
      w_emit_last = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_load      = 1'b1;
               w_state_nxt = i_last ? ST_DRAIN : ST_ACC;
            end
         end
         ST_ACC: begin
            if (w_accept) begin
               if (w_key_eq) begin
                  w_merge = 1'b1;
               end else begin
                  w_emit = 1'b1;
                  w_load = 1'b1;
               end
               w_state_nxt = i_last ? ST_DRAIN : ST_ACC;
            end
         end
         ST_DRAIN: begin
            if (w_out_free) begin
               w_emit      = 1'b1;
               w_emit_last = 1'b1;
               w_state_nxt = ST_EMPTY;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // Accumulator: a fresh triple starts at hits=1; an equal key sums in saturating
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc_key  <= '0;
         r_acc_sum  <= '0;
         r_acc_hits <= '0;
         r_acc_sat  <= 1'b0;
      end else if (w_load) begin
         r_acc_key  <= key_of(i_data);
         r_acc_sum  <= i_data[V_MSB:0];
         r_acc_hits <= {{(CW-1){1'b0}}, 1'b1};
         r_acc_sat  <= 1'b0;
      end else if (w_merge) begin
         r_acc_sum  <= w_sum_add;
         r_acc_sat  <= r_acc_sat | w_sum_ovf;
         // The count stays pinned at max once it has reached it
         if (!w_hits_ovf) begin
            r_acc_hits <= w_hits_add;
         end
      end
   end

   // Output register: loaded on emit, otherwise held until downstream accepts
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_o_valid <= 1'b0;
         r_o_last  <= 1'b0;
         r_o_data  <= '0;
         r_o_hits  <= '0;
         r_o_sat   <= 1'b0;
      end else if (w_emit) begin
         r_o_valid <= 1'b1;
         r_o_last  <= w_emit_last;
         r_o_data  <= {r_acc_key, r_acc_sum};
         r_o_hits  <= r_acc_hits;
         r_o_sat   <= r_acc_sat;
      end else if (o_ready) begin
         r_o_valid <= 1'b0;
      end
   end

   assign o_valid = r_o_valid;
   assign o_last  = r_o_last;
   assign o_data  = r_o_data;
   assign o_hits  = r_o_hits;
   assign o_sat   = r_o_sat;

endmodule
`default_nettype wire

// File: tb/tb_sdmf_triple_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdmf_triple_accum
//  Description : Self-checking bench for sdmf_triple_accum.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdmf_triple_accum;

   localparam int DW = 24;
   localparam int CW = 8;

   logic          clk     = 1'b0;
   logic          reset_n = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_last  = 1'b0;
   logic [DW-1:0] i_data  = '0;
   logic          o_ready = 1'b1;
   logic          i_ready;
   logic          o_valid;
   logic          o_last;
   logic [DW-1:0] o_data;
   logic [CW-1:0] o_hits;
   logic          o_sat;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sdmf_triple_accum dut (
      .clk     (clk),
      .reset_n (reset_n),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .i_last  (i_last),
      .i_data  (i_data),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_last  (o_last),
      .o_data  (o_data),
      .o_hits  (o_hits),
      .o_sat   (o_sat)
   );

   typedef struct packed {
      logic        last;
      logic        sat;
      logic [7:0]  hits;
      logic [23:0] data;
   } out_t;

   typedef struct packed {
      logic        last;
      logic [23:0] data;
   } in_t;

   typedef struct {
      logic        v;
      logic        l;
      logic [23:0] d;
      logic        ordy;
      logic        exp_irdy;
      logic        exp_ov;
      out_t        exp_o;
   } vec_t;

   in_t  in_q[$];
   out_t out_q[$];
   out_t exp_q[$];
   bit   mon_en  = 1'b0;
   bit   stalled = 1'b0;
   out_t held;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] trip(input int c, input int t, input int v);
      return {8'(c), 8'(t), 8'(v)};
   endfunction

   function automatic out_t cur_out();
      return {o_last, o_sat, o_hits, o_data};
   endfunction

   function automatic vec_t mk(input logic v, input logic l, input logic [23:0] d,
                               input logic ordy, input logic irdy, input logic ov,
                               input logic el, input logic es, input int eh,
                               input logic [23:0] ed);
      vec_t r;
      r.v = v; r.l = l; r.d = d; r.ordy = ordy;
      r.exp_irdy = irdy; r.exp_ov = ov;
      r.exp_o = {el, es, 8'(eh), ed};
      return r;
   endfunction

   // Reference: walk the accepted stream, group runs of equal key inside a frame
   task automatic build_expected();
      int          i;
      int          total;
      int          cnt;
      logic [15:0] key;
      logic        lst;
      exp_q.delete();
      i = 0;
      while (i < in_q.size()) begin
         key   = in_q[i].data[23:8];
         total = 0;
         cnt   = 0;
         lst   = 1'b0;
         while (i < in_q.size() && !lst && (cnt == 0 || in_q[i].data[23:8] == key)) begin
            total += int'(in_q[i].data[7:0]);
            cnt++;
            lst = in_q[i].last;
            i++;
         end
         exp_q.push_back({lst, (total > 255), 8'((cnt > 255) ? 255 : cnt),
                          key, 8'((total > 255) ? 255 : total)});
      end
   endtask

   // Stream monitor: records handshakes and checks outputs hold while stalled
   always @(negedge clk) begin
      if (mon_en) begin
         if (i_valid && i_ready) in_q.push_back({i_last, i_data});
         if (o_valid && o_ready) out_q.push_back(cur_out());
         if (stalled) check("stall_hold", {o_valid, cur_out()}, {1'b1, held});
         stalled = o_valid && !o_ready;
         held    = cur_out();
      end else begin
         stalled = 1'b0;
      end
   end

   vec_t        tbl[20];
   logic [15:0] pk;
   bit          acc;

   initial begin
      // ---------------- reset values ----------------
      #12;
      check("rst_o_valid", o_valid, 0);
      check("rst_o_last",  o_last,  0);
      check("rst_o_data",  o_data,  0);
      check("rst_o_hits",  o_hits,  0);
      check("rst_o_sat",   o_sat,   0);
      check("rst_i_ready", i_ready, 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("post_rst_i_ready", i_ready, 1);

      // ---------------- directed table ----------------
      tbl[0]  = mk(1, 0, trip(1, 2, 5),   1, 1, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 0, trip(1, 2, 7),   1, 1, 0, 0, 0, 0, 0);
      tbl[2]  = mk(1, 1, trip(3, 2, 1),   1, 1, 1, 0, 0, 2, trip(1, 2, 12));
      tbl[3]  = mk(0, 0, 0,               1, 0, 1, 1, 0, 1, trip(3, 2, 1));
      tbl[4]  = mk(0, 0, 0,               1, 1, 0, 0, 0, 0, 0);
      tbl[5]  = mk(1, 1, trip(5, 6, 200), 1, 1, 0, 0, 0, 0, 0);
      tbl[6]  = mk(0, 0, 0,               1, 0, 1, 1, 0, 1, trip(5, 6, 200));
      tbl[7]  = mk(0, 0, 0,               1, 1, 0, 0, 0, 0, 0);
      tbl[8]  = mk(1, 1, trip(7, 7, 10),  1, 1, 0, 0, 0, 0, 0);
      tbl[9]  = mk(1, 0, trip(7, 7, 20),  1, 0, 1, 1, 0, 1, trip(7, 7, 10));
      tbl[10] = mk(1, 1, trip(7, 7, 20),  1, 1, 0, 0, 0, 0, 0);
      tbl[11] = mk(0, 0, 0,               1, 0, 1, 1, 0, 1, trip(7, 7, 20));
      tbl[12] = mk(0, 0, 0,               1, 1, 0, 0, 0, 0, 0);
      tbl[13] = mk(1, 0, trip(9, 1, 250), 1, 1, 0, 0, 0, 0, 0);
      tbl[14] = mk(1, 0, trip(9, 1, 10),  1, 1, 0, 0, 0, 0, 0);
      tbl[15] = mk(1, 1, trip(9, 2, 3),   0, 1, 1, 0, 1, 2, trip(9, 1, 255));
      tbl[16] = mk(0, 0, 0,               0, 0, 1, 0, 1, 2, trip(9, 1, 255));
      tbl[17] = mk(0, 0, 0,               1, 0, 1, 1, 0, 1, trip(9, 2, 3));
      tbl[18] = mk(0, 0, 0,               0, 0, 1, 1, 0, 1, trip(9, 2, 3));
      tbl[19] = mk(0, 0, 0,               1, 1, 0, 0, 0, 0, 0);

      for (int r = 0; r < 20; r++) begin
         i_valid = tbl[r].v;
         i_last  = tbl[r].l;
         i_data  = tbl[r].d;
         o_ready = tbl[r].ordy;
         #1;
         check($sformatf("tbl%0d_i_ready", r), i_ready, tbl[r].exp_irdy);
         tick();
         check($sformatf("tbl%0d_o_valid", r), o_valid, tbl[r].exp_ov);
         if (tbl[r].exp_ov) check($sformatf("tbl%0d_out", r), cur_out(), tbl[r].exp_o);
      end

      // ---------------- 300 saturating triples ----------------
      acc = 1'b1;
      o_ready = 1'b1;
      for (int n = 1; n <= 300; n++) begin
         i_valid = 1'b1;
         i_data  = trip(8'h11, 8'h22, 255);
         i_last  = (n == 300);
         #1;
         if (!i_ready) acc = 1'b0;
         tick();
      end
      i_valid = 1'b0;
      i_last  = 1'b0;
      check("sat_all_accepted", acc, 1);
      check("sat_drain_pending", o_valid, 0);
      tick();
      check("sat_o_valid", o_valid, 1);
      check("sat_out", cur_out(), {1'b1, 1'b1, 8'd255, trip(8'h11, 8'h22, 255)});
      tick();

      // ---------------- randomized stream vs reference ----------------
      in_q.delete();
      out_q.delete();
      pk = 16'h0000;
      mon_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         i_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 0) pk = {8'($urandom_range(0, 2)), 8'($urandom_range(0, 1))};
         i_data  = {pk, 8'($urandom_range(0, 255))};
         i_last  = ($urandom_range(0, 7) == 0);
         o_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
         i_valid = 1'b1;
         i_last  = 1'b1;
         i_data  = {pk, 8'($urandom_range(0, 255))};
         o_ready = 1'b1;
         #1;
         acc = i_ready;
         tick();
      end
      check("rand_final_accept", acc, 1);
      i_valid = 1'b0;
      i_last  = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      mon_en = 1'b0;
      build_expected();
      check("rand_count", out_q.size(), exp_q.size());
      for (int k = 0; k < out_q.size() && k < exp_q.size(); k++)
         check($sformatf("rand_out%0d", k), out_q[k], exp_q[k]);

      // ---------------- reset mid-frame ----------------
      o_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         i_valid = 1'b1;
         i_last  = 1'b0;
         i_data  = trip(0, k, 1);
         tick();
      end
      i_valid = 1'b0;
      check("mid_pre_o_valid", o_valid, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_o_valid", o_valid, 0);
      check("mid_rst_i_ready", i_ready, 0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      i_valid = 1'b1;
      i_last  = 1'b1;
      i_data  = trip(0, 0, 9);
      #1;
      check("mid_new_i_ready", i_ready, 1);
      tick();
      i_valid = 1'b0;
      i_last  = 1'b0;
      check("mid_new_latency1", o_valid, 0);
      check("mid_new_drain_busy", i_ready, 0);
      tick();
      check("mid_new_o_valid", o_valid, 1);
      check("mid_new_out", cur_out(), {1'b1, 1'b0, 8'd1, trip(0, 0, 9)});
      tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
`default_nettype wire
